// File: rtl/ll_pkg.sv
// rtl/ll_pkg.sv - shared constants and types for the linked-list walker
package ll_pkg;

  localparam int PTR_W   = 4;
  localparam int DATA_W  = 8;
  localparam int HOP_MAX = 2**PTR_W - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  next;
    logic              last;
  } node_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } walk_state_t;

endpackage

// File: rtl/ll_walker_if.sv
// rtl/ll_walker_if.sv - head-pointer, table-write and node-output bundle
interface ll_walker_if #(
  parameter int PTR_W  = ll_pkg::PTR_W,
  parameter int DATA_W = ll_pkg::DATA_W
);
  logic [PTR_W-1:0]  in_ptr;
  logic              in_ptr_vld;
  logic              in_ptr_rdy;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [PTR_W-1:0]  wr_next;
  logic              wr_last;

  logic [PTR_W-1:0]  out_ptr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_err;
  logic              out_vld;
  logic              out_rdy;

  modport master (
    output in_ptr, in_ptr_vld, wr_en, wr_addr, wr_data, wr_next, wr_last, out_rdy,
    input  in_ptr_rdy, out_ptr, out_data, out_last, out_err, out_vld
  );

  modport slave (
    input  in_ptr, in_ptr_vld, wr_en, wr_addr, wr_data, wr_next, wr_last, out_rdy,
    output in_ptr_rdy, out_ptr, out_data, out_last, out_err, out_vld
  );
endinterface

// File: rtl/ll_walker_node_table.sv
// rtl/ll_walker_node_table.sv - node storage, sync write, combinational read
module ll_node_table #(
  parameter int PTR_W  = ll_pkg::PTR_W,
  parameter int DATA_W = ll_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [PTR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [PTR_W-1:0]  wr_next_i,
  input  logic              wr_last_i,
  input  logic [PTR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [PTR_W-1:0]  rd_next_o,
  output logic              rd_last_o
);
  localparam int DEPTH = 2**PTR_W;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  next_q [DEPTH];
  logic              last_q [DEPTH];

  // Every entry resets to an isolated tail node so an unloaded walk ends at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        next_q[i] <= '0;
        last_q[i] <= 1'b1;
      end
    end else if (wr_en_i) begin
      data_q[wr_addr_i] <= wr_data_i;
      next_q[wr_addr_i] <= wr_next_i;
      last_q[wr_addr_i] <= wr_last_i;
    end
  end

  assign rd_data_o = data_q[rd_addr_i];
  assign rd_next_o = next_q[rd_addr_i];
  assign rd_last_o = last_q[rd_addr_i];
endmodule

// File: rtl/ll_walker.sv
// rtl/ll_walker.sv - linked-list walker top; LL_WALKER_STATS_EN adds walk/node counters
module ll_walker
  import ll_pkg::*;
#(
  parameter int PTR_W  = ll_pkg::PTR_W,
  parameter int DATA_W = ll_pkg::DATA_W
) (
  input  logic        clk,
  input  logic        rst_n,
  ll_walker_if.slave  bus
`ifdef LL_WALKER_STATS_EN
  ,
  output logic [15:0] walk_cnt,
  output logic [15:0] node_cnt
`endif
);
  localparam int unsigned HOP_LIM = 2**PTR_W - 1;

  walk_state_t       state_q, state_d;
  logic [PTR_W-1:0]  cur_q, cur_d;
  logic [PTR_W-1:0]  hop_q, hop_d;
  logic [PTR_W-1:0]  next_q, next_d;
  logic [PTR_W-1:0]  out_ptr_q, out_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_err_q, out_err_d;
  logic              out_vld_q, out_vld_d;

  logic [DATA_W-1:0] rd_data;
  logic [PTR_W-1:0]  rd_next;
  logic              rd_last;
  logic              hop_at_max;

  ll_node_table #(.PTR_W(PTR_W), .DATA_W(DATA_W)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .wr_next_i (bus.wr_next),
    .wr_last_i (bus.wr_last),
    .rd_addr_i (cur_q),
    .rd_data_o (rd_data),
    .rd_next_o (rd_next),
    .rd_last_o (rd_last)
  );

  assign hop_at_max = (hop_q == HOP_LIM[PTR_W-1:0]);

  // Walk state and the held output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      hop_q      <= '0;
      next_q     <= '0;
      out_ptr_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      hop_q      <= hop_d;
      next_q     <= next_d;
      out_ptr_q  <= out_ptr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_err_q  <= out_err_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // Next state: accept head, snapshot node (read-before-write), hand off beat
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    hop_d      = hop_q;
    next_d     = next_q;
    out_ptr_d  = out_ptr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_err_d  = out_err_q;
    out_vld_d  = out_vld_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_ptr_vld) begin
          cur_d   = bus.in_ptr;
          hop_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_ptr_d  = cur_q;
        out_data_d = rd_data;
        next_d     = rd_next;
        out_last_d = rd_last | hop_at_max;
        out_err_d  = ~rd_last & hop_at_max;
        out_vld_d  = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (bus.out_rdy) begin
          out_vld_d = 1'b0;
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            cur_d   = next_q;
            hop_d   = hop_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ptr_rdy = (state_q == IDLE);
  assign bus.out_ptr    = out_ptr_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_vld    = out_vld_q;

`ifdef LL_WALKER_STATS_EN
  logic [15:0] walk_cnt_q;
  logic [15:0] node_cnt_q;

  // Count accepted beats and completed walks, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_cnt_q <= '0;
      node_cnt_q <= '0;
    end else if (out_vld_q && bus.out_rdy) begin
      node_cnt_q <= node_cnt_q + 16'd1;
      if (out_last_q) walk_cnt_q <= walk_cnt_q + 16'd1;
    end
  end

  assign walk_cnt = walk_cnt_q;
  assign node_cnt = node_cnt_q;
`endif
endmodule

// File: tb/tb_ll_walker.sv
// tb/tb_ll_walker.sv - directed self-checking bench for ll_walker
module tb_ll_walker;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ll_walker_if bus ();

`ifdef LL_WALKER_STATS_EN
  logic [15:0] walk_cnt;
  logic [15:0] node_cnt;
`endif

  ll_walker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef LL_WALKER_STATS_EN
    ,
    .walk_cnt (walk_cnt),
    .node_cnt (node_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] p, input logic [7:0] d,
                          input logic l, input logic e);
    chk({tag, "_vld"},  32'(bus.out_vld),  32'd1);
    chk({tag, "_ptr"},  32'(bus.out_ptr),  32'(p));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_last"}, 32'(bus.out_last), 32'(l));
    chk({tag, "_err"},  32'(bus.out_err),  32'(e));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [3:0] n, input logic l);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_next = n; bus.wr_last = l;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic head(input string tag, input logic [3:0] p);
    chk({tag, "_head_rdy"}, 32'(bus.in_ptr_rdy), 32'd1);
    bus.in_ptr = p; bus.in_ptr_vld = 1'b1;
    step();
    bus.in_ptr_vld = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(bus.in_ptr_rdy), 32'd1);
    chk({tag, "_vld"}, 32'(bus.out_vld),    32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    bus.in_ptr = '0; bus.in_ptr_vld = 1'b0; bus.out_rdy = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_next = '0; bus.wr_last = 1'b0;
    repeat (2) step();
    chk("rst_rdy",  32'(bus.in_ptr_rdy), 32'd1);
    chk("rst_vld",  32'(bus.out_vld),    32'd0);
    chk("rst_ptr",  32'(bus.out_ptr),    32'd0);
    chk("rst_data", 32'(bus.out_data),   32'd0);
    chk("rst_last", 32'(bus.out_last),   32'd0);
    chk("rst_err",  32'(bus.out_err),    32'd0);
    rst_n = 1'b1;
    step();

    // Unloaded table: single tail node
    head("t1", 4'd3);
    chk("t1_fetch_vld", 32'(bus.out_vld), 32'd0);
    step(); chk_beat("t1_b1", 4'd3, 8'h00, 1'b1, 1'b0);
    step(); chk_idle("t1_end");

    rst_n = 1'b0; step(); rst_n = 1'b1; step();

    // 2 -> 5 -> 9, free-running output
    wr(4'd2, 8'hA1, 4'd5, 1'b0);
    wr(4'd5, 8'hB2, 4'd9, 1'b0);
    wr(4'd9, 8'hC3, 4'd0, 1'b1);
    head("t2", 4'd2);
    chk("t2_n0_vld", 32'(bus.out_vld), 32'd0);
    step(); chk_beat("t2_b1", 4'd2, 8'hA1, 1'b0, 1'b0);
    step(); chk("t2_n2_vld", 32'(bus.out_vld), 32'd0);
    step(); chk_beat("t2_b2", 4'd5, 8'hB2, 1'b0, 1'b0);
    step(); chk("t2_n4_vld", 32'(bus.out_vld), 32'd0);
    step(); chk_beat("t2_b3", 4'd9, 8'hC3, 1'b1, 1'b0);
    step(); chk_idle("t2_end");
`ifdef LL_WALKER_STATS_EN
    chk("t2_walk_cnt", 32'(walk_cnt), 32'd1);
    chk("t2_node_cnt", 32'(node_cnt), 32'd3);
`endif

    // Backpressure on beat 2
    head("t3", 4'd2);
    step(); chk_beat("t3_b1", 4'd2, 8'hA1, 1'b0, 1'b0);
    step(); bus.out_rdy = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk_beat("t3_hold", 4'd5, 8'hB2, 1'b0, 1'b0);
      step();
    end
    bus.out_rdy = 1'b1;
    step(); step(); chk_beat("t3_b3", 4'd9, 8'hC3, 1'b1, 1'b0);
    step(); chk_idle("t3_end");

    // Self-loop runs to the hop limit
    wr(4'd7, 8'h77, 4'd7, 1'b0);
    head("t4", 4'd7);
    for (int i = 0; i < 16; i++) begin
      step();
      chk_beat("t4_loop", 4'd7, 8'h77, (i == 15), (i == 15));
      step();
    end
    chk_idle("t4_end");

    // Write to node 5 during its FETCH: old contents emitted
    head("t5", 4'd2);
    step(); chk_beat("t5_b1", 4'd2, 8'hA1, 1'b0, 1'b0);
    step();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'hEE; bus.wr_next = 4'd9; bus.wr_last = 1'b0;
    step(); bus.wr_en = 1'b0;
    chk_beat("t5_b2_old", 4'd5, 8'hB2, 1'b0, 1'b0);
    step(); step(); chk_beat("t5_b3", 4'd9, 8'hC3, 1'b1, 1'b0);
    step();
    head("t5r", 4'd2);
    step(); chk_beat("t5r_b1", 4'd2, 8'hA1, 1'b0, 1'b0);
    step(); step(); chk_beat("t5r_b2_new", 4'd5, 8'hEE, 1'b0, 1'b0);
    step(); step(); chk_beat("t5r_b3", 4'd9, 8'hC3, 1'b1, 1'b0);
    step(); chk_idle("t5r_end");

    // Reset during SEND of beat 2
    head("t6", 4'd2);
    step(); chk_beat("t6_b1", 4'd2, 8'hA1, 1'b0, 1'b0);
    step(); bus.out_rdy = 1'b0;
    step(); chk_beat("t6_b2", 4'd5, 8'hEE, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  32'(bus.out_vld),    32'd0);
    chk("t6_rst_rdy",  32'(bus.in_ptr_rdy), 32'd1);
    chk("t6_rst_ptr",  32'(bus.out_ptr),    32'd0);
    chk("t6_rst_data", 32'(bus.out_data),   32'd0);
    step(); rst_n = 1'b1; bus.out_rdy = 1'b1;
    step();
    head("t6r", 4'd2);
    step(); chk_beat("t6r_b1", 4'd2, 8'h00, 1'b1, 1'b0);
    step(); chk_idle("t6r_end");
`ifdef LL_WALKER_STATS_EN
    chk("t6_walk_cnt", 32'(walk_cnt), 32'd1);
    chk("t6_node_cnt", 32'(node_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ll_walker.md
Name: ll_walker

Overview:
- Responder end of the pointer-request interface driven by req_gen. Accepts a 4-bit head pointer on a valid/ready handshake and walks a singly linked list held in an internal node table.
- Emits one node (pointer, data, last flag) per output handshake.
- Sits between req_gen and the display/LED logic in the linked-list demo. The node table is loaded through a dedicated write port.

Parameters:
- PTR_W, 4, pointer width; node table depth is 2**PTR_W.
- DATA_W, 8, payload width per node.

Ports:
- clk  in  1  system clock (divided_clk in the demo).
- rst_n  in  1  asynchronous active-low reset.
- in_ptr  in  PTR_W  head pointer of the list to walk.
- in_ptr_vld  in  1  head pointer valid.
- in_ptr_rdy  out  1  walker can accept a head pointer.
- wr_en  in  1  node table write strobe.
- wr_addr  in  PTR_W  node index to write.
- wr_data  in  DATA_W  node payload.
- wr_next  in  PTR_W  node next pointer.
- wr_last  in  1  node is list tail.
- out_ptr  out  PTR_W  index of the emitted node.
- out_data  out  DATA_W  payload of the emitted node.
- out_last  out  1  final node of this walk.
- out_err  out  1  walk terminated by hop limit (loop detected); valid with out_last.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  downstream accepts beat.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - in_ptr_rdy=1.
  - out_vld=0, out_ptr=0, out_data=0, out_last=0, out_err=0.
  - Hop counter 0.
  - Node table: all entries data=0, next=0, last=1.
- States: IDLE, FETCH, SEND.
- IDLE:
  - in_ptr_rdy=1.
  - On in_ptr_vld: cur_ptr<=in_ptr, hop<=0, go to FETCH.
- FETCH (one cycle, in_ptr_rdy=0):
  - Register the node at cur_ptr into the out_* fields.
  - out_last<=node.last | (hop==2**PTR_W-1).
  - out_err<=~node.last & (hop==2**PTR_W-1).
  - out_vld<=1, go to SEND.
- SEND:
  - out_* held stable while out_vld=1 and out_rdy=0.
  - On out_rdy with out_last=1: out_vld<=0, go to IDLE; in_ptr_rdy is high on the next cycle.
  - On out_rdy with out_last=0: cur_ptr<=node.next (registered in FETCH), hop<=hop+1, out_vld<=0, go to FETCH.
- Latency:
  - Head accept to first out_vld: 2 cycles.
  - Throughput: at most one node per 2 cycles.
- Hop counter:
  - PTR_W bits, saturating usage.
  - A walk emits at most 2**PTR_W nodes (16 by default), then forces out_last=1, out_err=1.
- Table writes:
  - Accepted in every state; take effect next cycle.
  - A write to cur_ptr in the same cycle as FETCH: FETCH registers the old contents (read-before-write).
  - A write to a node already emitted does not alter the held output.
- in_ptr_vld while in_ptr_rdy=0: ignored, no buffering. The source holds the pointer until accepted.
- A self-loop (next==own index, last=0) runs to the hop limit and ends with an error beat.
- Reset asserted mid-walk:
  - Immediate return to IDLE with reset values.
  - Node table reinitialised.
  - No partial beat completes.

Optional Feature:
- LL_WALKER_STATS_EN defined:
  - Adds outputs walk_cnt (16 bits) and node_cnt (16 bits), reset 0.
  - walk_cnt increments on each accepted out beat with out_last=1.
  - node_cnt increments on every accepted out beat.
  - Both counters wrap at 2**16.
  - out_err beats count toward both.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ll_pkg:
  - PTR_W and DATA_W default constants.
  - node_t struct {data, next, last}.
  - walk_state_t enum {IDLE, FETCH, SEND}.
  - HOP_MAX constant.
- One sub-module, ll_node_table:
  - 2**PTR_W register array of node_t.
  - Synchronous write port, combinational read port.
  - Async reset to data=0, next=0, last=1.

Test Plan:
- Reset only, in_ptr=3 vld -> first beat out_ptr=3, out_data=0x00, out_last=1, out_err=0, two cycles after accept.
- Load 2->5->9 (data 0xA1, 0xB2, 0xC3; 9 last), head 2, out_rdy=1 -> beats (2,A1,0), (5,B2,0), (9,C3,1) on cycles 2, 4, 6; in_ptr_rdy high on cycle 7.
- Same list, out_rdy low for 5 cycles on beat 2 -> out_ptr=5, out_data=0xB2 held stable; walk then completes normally.
- Node 7 self-loop (next=7, last=0), head 7 -> exactly 16 beats of out_ptr=7; the 16th has out_last=1, out_err=1.
- Write node 5 data=0xEE in the FETCH cycle for 5 -> beat shows 0xB2; a rewalk shows 0xEE.
- Assert rst_n=0 during SEND of beat 2 -> out_vld=0 and in_ptr_rdy=1 immediately. With LL_WALKER_STATS_EN, after the 3-node walk: walk_cnt=1, node_cnt=3.
